// File: rtl/cordic_if.sv
// Sample bus for the CORDIC pipeline: input sample fields and the matching result fields.
interface cordic_if #(
    parameter int IW = 16,
    parameter int OW = 18,
    parameter int PW = 12
);
    logic                 i_valid;
    logic                 i_mode;
    logic signed [IW-1:0] i_xval;
    logic signed [IW-1:0] i_yval;
    logic [PW-1:0]        i_phase;
    logic                 o_valid;
    logic                 o_mode;
    logic signed [OW-1:0] o_xval;
    logic signed [OW-1:0] o_yval;
    logic [PW-1:0]        o_phase;

    modport master (
        output i_valid, i_mode, i_xval, i_yval, i_phase,
        input  o_valid, o_mode, o_xval, o_yval, o_phase
    );
    modport slave (
        input  i_valid, i_mode, i_xval, i_yval, i_phase,
        output o_valid, o_mode, o_xval, o_yval, o_phase
    );
endinterface

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC: per-sample rotation/vectoring, one sample per enabled clock,
// latency NSTAGES+2 enabled edges, no gain compensation.
module cordic_stage #(
    parameter int             WW    = 18,
    parameter int             PWI   = 15,
    parameter int             SHIFT = 0,
    parameter logic [PWI-1:0] ATAN  = '0
) (
    input  logic                 mode,
    input  logic signed [WW-1:0] x,
    input  logic signed [WW-1:0] y,
    input  logic [PWI-1:0]       z,
    output logic signed [WW-1:0] x_n,
    output logic signed [WW-1:0] y_n,
    output logic [PWI-1:0]       z_n
);
    logic                 ccw;
    logic signed [WW-1:0] xs, ys;

    always_comb begin
        // Vectoring drives y toward zero; rotation drives the residual angle toward zero.
        ccw = mode ? y[WW-1] : ~z[PWI-1];
        xs  = x >>> SHIFT;
        ys  = y >>> SHIFT;
        if (ccw) begin
            x_n = x - ys;
            y_n = y + xs;
            z_n = z - ATAN;
        end else begin
            x_n = x + ys;
            y_n = y - xs;
            z_n = z + ATAN;
        end
    end
endmodule

module cordic_pipe #(
    parameter int IW      = 16,
    parameter int OW      = 18,
    parameter int PW      = 12,
    parameter int NSTAGES = 14
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    enable,
    cordic_if.slave bus
);
    localparam int WW     = IW + 2;
    localparam int PWI    = PW + 3;
    localparam int STAGES = NSTAGES + 1;

    // atan(2^-i) at 2^32 counts per turn, rounded to nearest at PWI bits.
    function automatic logic [PWI-1:0] atan_k(input int i);
        logic [31:0] t;
        logic [32:0] r;
        case (i)
            0:  t = 32'h2000_0000;  1:  t = 32'h12e4_051d;  2:  t = 32'h09fb_385b;
            3:  t = 32'h0511_11d4;  4:  t = 32'h028b_0d43;  5:  t = 32'h0145_d7e1;
            6:  t = 32'h00a2_f61e;  7:  t = 32'h0051_7c55;  8:  t = 32'h0028_be53;
            9:  t = 32'h0014_5f2e;  10: t = 32'h000a_2f98;  11: t = 32'h0005_17cc;
            12: t = 32'h0002_8be6;  13: t = 32'h0001_45f3;  14: t = 32'h0000_a2f9;
            15: t = 32'h0000_517c;  16: t = 32'h0000_28be;
            default: t = '0;
        endcase
        r = {1'b0, t} + (33'd1 << (31 - PWI));
        return r[31 -: PWI];
    endfunction

    logic [NSTAGES:0][WW-1:0]    xq, yq;
    logic [NSTAGES:0][PWI-1:0]   zq;
    logic [NSTAGES-1:0][WW-1:0]  xn, yn;
    logic [NSTAGES-1:0][PWI-1:0] zn;
    logic [STAGES:0]             vld_pipe, mode_pipe;

    logic signed [WW-1:0] xe, ye, x0, y0;
    logic [PWI-1:0]       z0;

    assign xe = {{(WW-IW){bus.i_xval[IW-1]}}, bus.i_xval};
    assign ye = {{(WW-IW){bus.i_yval[IW-1]}}, bus.i_yval};

    // Pre-rotation brings every sample into the +-90 degree convergence range.
    always_comb begin
        x0 = xe;
        y0 = ye;
        z0 = '0;
        if (bus.i_mode) begin
            if (xe[WW-1]) begin
                x0 = -xe;
                y0 = -ye;
                z0 = {1'b1, {(PWI-1){1'b0}}};
            end
        end else begin
            z0 = {2'b00, bus.i_phase[PW-3:0], 3'b000};
            case (bus.i_phase[PW-1 -: 2])
                2'b01:   begin x0 = -ye; y0 = xe;  end
                2'b10:   begin x0 = -xe; y0 = -ye; end
                2'b11:   begin x0 = ye;  y0 = -xe; end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        cordic_stage #(.WW(WW), .PWI(PWI), .SHIFT(k), .ATAN(atan_k(k))) u_stage (
            .mode(mode_pipe[k]), .x(xq[k]), .y(yq[k]), .z(zq[k]),
            .x_n(xn[k]), .y_n(yn[k]), .z_n(zn[k])
        );
    end

    logic [OW-1:0] xr, yr;
    logic [PW-1:0] zr;
    logic [PWI-1:0] zs;

    if (OW == WW) begin : g_pass
        assign xr = xq[NSTAGES];
        assign yr = yq[NSTAGES];
    end else begin : g_round
        localparam logic [WW-1:0] HALF = WW'(1) << (WW - OW - 1);
        logic [WW-1:0] xs, ys;
        assign xs = xq[NSTAGES] + HALF;
        assign ys = yq[NSTAGES] + HALF;
        assign xr = OW'(xs >> (WW - OW));
        assign yr = OW'(ys >> (WW - OW));
    end

    // Half-LSB add wraps naturally, so 0xFFF.8 lands on 0x000.
    assign zs = zq[NSTAGES] + PWI'(4);
    assign zr = PW'(zs >> 3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xq          <= '0;
            yq          <= '0;
            zq          <= '0;
            vld_pipe    <= '0;
            mode_pipe   <= '0;
            bus.o_xval  <= '0;
            bus.o_yval  <= '0;
            bus.o_phase <= '0;
        end else if (enable) begin
            xq[0]           <= x0;
            yq[0]           <= y0;
            zq[0]           <= z0;
            xq[NSTAGES:1]   <= xn;
            yq[NSTAGES:1]   <= yn;
            zq[NSTAGES:1]   <= zn;
            vld_pipe        <= {vld_pipe[STAGES-1:0], bus.i_valid};
            mode_pipe       <= {mode_pipe[STAGES-1:0], bus.i_mode};
            bus.o_xval      <= xr;
            bus.o_yval      <= yr;
            bus.o_phase     <= zr;
        end
    end

    assign bus.o_valid = vld_pipe[STAGES];
    assign bus.o_mode  = mode_pipe[STAGES];
endmodule

// File: doc/cordic_pipe.md
Name: cordic_pipe

Overview:
Parametrised, fully pipelined CORDIC engine with per-sample valid, clock-enable stall and run-time mode select per sample.
- Rotation mode (i_mode=0): rotates the input vector by i_phase. Used with (x,0) input for sine/cosine generation.
- Vectoring mode (i_mode=1): rotates the input vector onto +x and returns magnitude and angle.
- Sits between the phase accumulator/sample sources and the display/DSP datapath. Accepts one sample per enabled clock.

Parameters:
IW, 16, input width of i_xval/i_yval, signed two's complement
OW, 18, output width of o_xval/o_yval; legal range 8..IW+2
PW, 12, phase width; unsigned, 2^PW counts = 360 degrees
NSTAGES, 14, number of CORDIC iterations; legal range 4..IW+1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all pipeline state
enable  in  1  clock enable; low = whole pipeline holds (stall)
i_valid  in  1  input sample qualifier
i_mode  in  1  0 = rotation, 1 = vectoring
i_xval  in  IW  signed x input
i_yval  in  IW  signed y input
i_phase  in  PW  rotation angle (ignored in vectoring mode)
o_valid  out  1  output sample qualifier
o_mode  out  1  mode of the sample on the outputs
o_xval  out  OW  signed x result
o_yval  out  OW  signed y result
o_phase  out  PW  residual angle (rotation) or measured angle (vectoring)

Behaviour:
Reset:
- Asynchronous assertion clears every pipeline register, including all valid and mode flags.
- All outputs read 0 while reset is high and until the first valid sample emerges.
- Reset mid-operation discards all in-flight samples. No partial output follows deassertion.

Internal widths:
- Working width WW = IW+2; inputs sign-extended to WW.
- Internal phase width PWI = PW+3. The atan(2^-i) table holds constants scaled to 2^PWI per turn, rounded to nearest.

Pipeline (all registers advance only when enable=1):
- Stage 0 (pre-rotation):
  - Rotation: quadrant from i_phase[PW-1:PW-2]. 00 gives (x,y); 01 gives (-y,x); 10 gives (-x,-y); 11 gives (y,-x). Residual z = phase with the top two bits cleared, zero-extended to PWI.
  - Vectoring: if x<0, the vector becomes (-x,-y) and z = 180 degrees; otherwise z = 0.
- Stages 1..NSTAGES, iteration i = 0..NSTAGES-1, with d = +1 or -1:
  - x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i.
  - Rotation: d = sign of z (z>=0 gives +1). Vectoring: d = +1 if y<0, else -1; z accumulates the angle.
  - All phase arithmetic wraps modulo 2^PWI.
- Output stage: x and y rounded from WW to OW bits, round-half-up (add 1 at bit WW-OW-1, then truncate). When OW=WW the value passes through unchanged. z is rounded from PWI to PW bits, round-half-up, wrapping modulo 2^PW (0xFFF.8 becomes 0x000).
- Valid and mode ride alongside the data, one flag per stage.

Latency, throughput and gain:
- Latency is exactly NSTAGES+2 enabled clock edges from i_valid sampled to o_valid high.
- Throughput is one sample per enabled edge. Back-to-back samples are permitted with no bubbles required.
- enable=0 freezes every register, including o_valid. The same output is held for the entire stall.
- Invalid samples (i_valid=0) still propagate; outputs for them are don't-care but o_valid=0.
- No gain compensation: output magnitude = K*|input|, with K approximately 1.64676 for NSTAGES>=10.
- Saturation is not required. Inputs at the full-scale corner (-2^(IW-1), -2^(IW-1)) must not overflow WW.

Test Plan:
Defaults IW=16, OW=18, PW=12, NSTAGES=14; tolerance +/-4 LSB on x/y and +/-1 LSB on phase.

1. Rotation, x=16384, y=0, phases 0x000/0x400/0x800/0xC00 → (o_xval,o_yval) = (26981,0)/(0,26981)/(-26981,0)/(0,-26981), o_valid exactly 16 cycles after each i_valid.
2. Vectoring, (10000,10000) → o_phase=0x200, o_xval≈23289; (-10000,0) → o_phase=0x800, o_xval≈16468; (0,-10000) → o_phase=0xC00.
3. Streaming: 4096 consecutive phases with x=16384, one per clock, mixed i_mode every 3rd sample → 4096 o_valid pulses in order, each o_mode matching its input, sin/cos within tolerance.
4. Stall: enable pattern 1,0,0,1,0,1 during a stream → outputs and o_valid held during enable=0, no sample lost or duplicated, latency counted in enabled edges = 16.
5. Reset mid-flight: assert reset 7 cycles after 5 valid inputs → all outputs 0 immediately (asynchronous), no o_valid pulse after deassertion until new input + 16 cycles.
6. Corner and rounding: x=y=-32768 in vectoring mode → no wrap, o_phase≈0xA00; rerun case 1 with OW=16 → o_xval≈6745, confirming round-half-up behaviour.
